// File: rtl/scic_io_ctrl.sv
// rtl/scic_io_ctrl.sv - SCIC switch/LED I/O controller with debounce, change flags and interrupt
module scic_io_ctrl #(
   parameter int SW_WIDTH        = 4,
   parameter int LED_WIDTH       = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [SW_WIDTH-1:0]   switches,
   output logic [LED_WIDTH-1:0]  LEDs,
   input  logic [1:0]            addr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  irq
);

   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_SW   = 2'd0;
   localparam logic [1:0] ADDR_LED  = 2'd1;
   localparam logic [1:0] ADDR_CHG  = 2'd2;
   localparam logic [1:0] ADDR_MASK = 2'd3;

   // two-flop synchroniser stages for the asynchronous switch inputs
   logic [SW_WIDTH-1:0]  sync_s1;
   logic [SW_WIDTH-1:0]  sync_s2;

   // architectural registers
   logic [SW_WIDTH-1:0]  sw_reg;
   logic [LED_WIDTH-1:0] led_reg;
   logic [SW_WIDTH-1:0]  chg_reg;
   logic [SW_WIDTH-1:0]  mask_reg;

   // per-bit debounce counters; they only ever count up to CNT_LAST
   logic [CNT_WIDTH-1:0] db_cnt [SW_WIDTH];

   // bits whose debounced value flips at the coming edge
   logic [SW_WIDTH-1:0]  db_accept;

   // write decode
   logic                 wr_led;
   logic                 wr_chg;
   logic                 wr_mask;
   logic [SW_WIDTH-1:0]  chg_clear;

   // read data selected by addr, zero-extended to the bus width
   logic [DATA_WIDTH-1:0] rd_mux;

   // upper write-data bits beyond the register widths carry no meaning
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   assign wr_led    = wr_en && (addr == ADDR_LED);
   assign wr_chg    = wr_en && (addr == ADDR_CHG);
   assign wr_mask   = wr_en && (addr == ADDR_MASK);
   assign chg_clear = wr_chg ? wdata[SW_WIDTH-1:0] : '0;

   assign LEDs = led_reg;

   // interrupt comes purely from registered flags and enables
   assign irq = |(chg_reg & mask_reg);

   // synchronise the raw switch inputs into the clock domain
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= switches;
         sync_s2 <= sync_s1;
      end
   end

   // a bit is accepted once it has disagreed with SW for DEBOUNCE_CYCLES edges
   always_comb begin
      db_accept = '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
         db_accept[i] = (sync_s2[i] != sw_reg[i]) && (db_cnt[i] == CNT_LAST);
      end
   end

   // debounce counters and the debounced switch register
   always_ff @(posedge clock) begin
      if (reset) begin
         sw_reg <= '0;
         for (int i = 0; i < SW_WIDTH; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SW_WIDTH; i++) begin
            if (sync_s2[i] == sw_reg[i]) begin
               db_cnt[i] <= '0;
            end else if (db_accept[i]) begin
               db_cnt[i] <= '0;
               sw_reg[i] <= sync_s2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // LED, MASK and CHG registers; a fresh change beats a same-edge clear
   always_ff @(posedge clock) begin
      if (reset) begin
         led_reg  <= '0;
         mask_reg <= '0;
         chg_reg  <= '0;
      end else begin
         if (wr_led) begin
            led_reg <= wdata[LED_WIDTH-1:0];
         end
         if (wr_mask) begin
            mask_reg <= wdata[SW_WIDTH-1:0];
         end
         chg_reg <= (chg_reg & ~chg_clear) | db_accept;
      end
   end

   // select the addressed register as it stands before the current edge
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_SW:   rd_mux = DATA_WIDTH'(sw_reg);
         ADDR_LED:  rd_mux = DATA_WIDTH'(led_reg);
         ADDR_CHG:  rd_mux = DATA_WIDTH'(chg_reg);
         ADDR_MASK: rd_mux = DATA_WIDTH'(mask_reg);
      endcase
   end

   // registered read port; rdata holds between reads
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_scic_io_ctrl.sv
// tb/tb_scic_io_ctrl.sv - self-checking bench for scic_io_ctrl
module tb_scic_io_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] switches;
   logic [3:0] LEDs;
   logic [1:0] addr;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rvalid;
   logic       irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic       wr;
      logic       rd;
      logic [1:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_rdata;
      logic [3:0] exp_leds;
      logic       exp_irq;
   } vec_t;

   vec_t tab_rst[$];
   vec_t tab_reg[$];

   scic_io_ctrl #(
      .SW_WIDTH(4),
      .LED_WIDTH(4),
      .DATA_WIDTH(8),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .switches(switches),
      .LEDs(LEDs),
      .addr(addr),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .wdata(wdata),
      .rdata(rdata),
      .rvalid(rvalid),
      .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t vec(input string n, input logic wr, input logic rd,
                                input logic [1:0] a, input logic [7:0] wd,
                                input logic [7:0] exp_rd, input logic [3:0] leds,
                                input logic exp_irq);
      vec_t v;
      v.name      = n;
      v.wr        = wr;
      v.rd        = rd;
      v.addr      = a;
      v.wd        = wd;
      v.exp_rdata = exp_rd;
      v.exp_leds  = leds;
      v.exp_irq   = exp_irq;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v);
      wr_en = v.wr;
      rd_en = v.rd;
      addr  = v.addr;
      wdata = v.wd;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check({v.name, " rvalid"}, 32'(rvalid), 32'(v.rd));
      if (v.rd) check({v.name, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
      check({v.name, " leds"}, 32'(LEDs), 32'(v.exp_leds));
      check({v.name, " irq"}, 32'(irq), 32'(v.exp_irq));
   endtask

   initial begin
      // name, wr, rd, addr, wdata, exp_rdata, exp_leds, exp_irq
      tab_rst.push_back(vec("rst rd sw",   0, 1, 2'd0, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst idle0",   0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst rd led",  0, 1, 2'd1, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst idle1",   0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst rd chg",  0, 1, 2'd2, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst idle2",   0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst rd mask", 0, 1, 2'd3, 8'h00, 8'h00, 4'h0, 0));
      tab_rst.push_back(vec("rst idle3",   0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 0));

      tab_reg.push_back(vec("wr led 0c",   1, 0, 2'd1, 8'h0C, 8'h00, 4'hC, 0));
      tab_reg.push_back(vec("rd led 0c",   0, 1, 2'd1, 8'h00, 8'h0C, 4'hC, 0));
      tab_reg.push_back(vec("wr led ff",   1, 0, 2'd1, 8'hFF, 8'h00, 4'hF, 0));
      tab_reg.push_back(vec("rd led 0f",   0, 1, 2'd1, 8'h00, 8'h0F, 4'hF, 0));
      tab_reg.push_back(vec("wr sw ro",    1, 0, 2'd0, 8'hAA, 8'h00, 4'hF, 0));
      tab_reg.push_back(vec("rd sw ro",    0, 1, 2'd0, 8'h00, 8'h05, 4'hF, 0));
      tab_reg.push_back(vec("wr+rd led",   1, 1, 2'd1, 8'h03, 8'h0F, 4'h3, 0));
      tab_reg.push_back(vec("rd led 03",   0, 1, 2'd1, 8'h00, 8'h03, 4'h3, 0));
      tab_reg.push_back(vec("wr mask ff",  1, 0, 2'd3, 8'hFF, 8'h00, 4'h3, 0));
      tab_reg.push_back(vec("rd mask 0f",  0, 1, 2'd3, 8'h00, 8'h0F, 4'h3, 0));
      tab_reg.push_back(vec("wr mask 01",  1, 0, 2'd3, 8'h01, 8'h00, 4'h3, 0));
      tab_reg.push_back(vec("rd mask 01",  0, 1, 2'd3, 8'h00, 8'h01, 4'h3, 0));
      tab_reg.push_back(vec("rd chg 00",   0, 1, 2'd2, 8'h00, 8'h00, 4'h3, 0));

      reset    = 1'b1;
      switches = 4'b1010;
      addr     = 2'd0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wdata    = 8'h00;

      // reset and defaults
      repeat (2) tick();
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset rdata",  32'(rdata),  32'd0);
      check("reset leds",   32'(LEDs),   32'd0);
      check("reset irq",    32'(irq),    32'd0);
      reset    = 1'b0;
      switches = 4'b0000;
      foreach (tab_rst[i]) apply_vec(tab_rst[i]);

      // debounce latency: SW flips at edge k+5, first visible to a read at k+6
      switches = 4'b0101;
      rd_en    = 1'b1;
      addr     = 2'd0;
      for (int m = 0; m < 8; m++) begin
         tick();
         check($sformatf("latency m=%0d rdata", m), 32'(rdata), (m >= 6) ? 32'h05 : 32'h00);
         check($sformatf("latency m=%0d rvalid", m), 32'(rvalid), 32'd1);
      end
      rd_en = 1'b0;
      apply_vec(vec("latency chg",   0, 1, 2'd2, 8'h00, 8'h05, 4'h0, 0));
      apply_vec(vec("latency clr",   1, 0, 2'd2, 8'h05, 8'h00, 4'h0, 0));
      apply_vec(vec("latency chg0",  0, 1, 2'd2, 8'h00, 8'h00, 4'h0, 0));

      // glitch rejection: 3-cycle pulse is ignored
      switches = 4'b1101;
      repeat (3) tick();
      switches = 4'b0101;
      repeat (8) tick();
      apply_vec(vec("glitch3 sw",    0, 1, 2'd0, 8'h00, 8'h05, 4'h0, 0));
      apply_vec(vec("glitch3 chg",   0, 1, 2'd2, 8'h00, 8'h00, 4'h0, 0));

      // 6-cycle pulse is accepted, then the release is accepted too
      switches = 4'b1101;
      repeat (6) tick();
      switches = 4'b0101;
      apply_vec(vec("pulse6 sw hi",  0, 1, 2'd0, 8'h00, 8'h0D, 4'h0, 0));
      repeat (10) tick();
      apply_vec(vec("pulse6 sw lo",  0, 1, 2'd0, 8'h00, 8'h05, 4'h0, 0));
      apply_vec(vec("pulse6 chg",    0, 1, 2'd2, 8'h00, 8'h08, 4'h0, 0));
      apply_vec(vec("pulse6 clr",    1, 0, 2'd2, 8'h08, 8'h00, 4'h0, 0));

      // LED / MASK register access, ends with MASK=0x01 and LEDs=3
      foreach (tab_reg[i]) apply_vec(tab_reg[i]);

      // interrupt: bits 0 and 1 change, bit 0 is enabled
      switches = 4'b0110;
      repeat (8) tick();
      apply_vec(vec("irq chg 03",    0, 1, 2'd2, 8'h00, 8'h03, 4'h3, 1));
      apply_vec(vec("irq w1c bit0",  1, 0, 2'd2, 8'h01, 8'h00, 4'h3, 0));
      apply_vec(vec("irq chg 02",    0, 1, 2'd2, 8'h00, 8'h02, 4'h3, 0));

      // clear of bit 1 lands on the edge where bit 1 changes again
      switches = 4'b0100;
      repeat (5) tick();
      apply_vec(vec("conflict w1c",  1, 0, 2'd2, 8'h02, 8'h00, 4'h3, 0));
      apply_vec(vec("conflict chg",  0, 1, 2'd2, 8'h00, 8'h02, 4'h3, 0));
      apply_vec(vec("conflict sw",   0, 1, 2'd0, 8'h00, 8'h04, 4'h3, 0));
      apply_vec(vec("mask 02 irq",   1, 0, 2'd3, 8'h02, 8'h00, 4'h3, 1));

      // reset during a pending debounce and a read
      switches = 4'b0111;
      repeat (4) tick();
      reset = 1'b1;
      rd_en = 1'b1;
      addr  = 2'd0;
      tick();
      check("midrst rvalid", 32'(rvalid), 32'd0);
      check("midrst rdata",  32'(rdata),  32'd0);
      check("midrst leds",   32'(LEDs),   32'd0);
      check("midrst irq",    32'(irq),    32'd0);
      reset = 1'b0;
      rd_en = 1'b0;
      tick();
      check("postrst rvalid", 32'(rvalid), 32'd0);
      rd_en = 1'b1;
      for (int m = 2; m <= 8; m++) begin
         tick();
         check($sformatf("postrst m=%0d rdata", m), 32'(rdata), (m >= 7) ? 32'h07 : 32'h00);
      end
      rd_en = 1'b0;
      tick();
      check("postrst idle rvalid", 32'(rvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
